// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded LDR/STR into a single valid/ready memory
// transaction and returns the load result for register-file write-back.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | no access in flight; waits for REQUEST with LDR/STR
// REQUESTING | operands latched; valid is raised on the next edge
// WAITING    | valid held with stable address/data until matching ready
// DONE       | access complete; waits for UPDATE before returning to IDLE
module load_store_unit #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        DONE       = 2'd3
    } lsu_state_t;

    lsu_state_t           state;
    logic                 op_read;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic [ADDR_BITS-1:0] rs_addr;

    // Address is the low ADDR_BITS of rs; zero-extended if the bus is wider.
    generate
        if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
            assign rs_addr = rs[ADDR_BITS-1:0];
        end else begin : g_addr_ext
            assign rs_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            op_read           <= 1'b0;
            addr_q            <= '0;
            data_q            <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        addr_q  <= rs_addr;
                        data_q  <= rt;
                        op_read <= decoded_mem_read_enable;
                        state   <= REQUESTING;
                    end
                end
                REQUESTING: begin
                    if (op_read) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= addr_q;
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= addr_q;
                        mem_write_data    <= data_q;
                    end
                    state <= WAITING;
                end
                WAITING: begin
                    // Only the ready of the channel in use can complete the access.
                    if (op_read && mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        lsu_out        <= mem_read_data;
                        state          <= DONE;
                    end else if (!op_read && mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lsu_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: load, store, operand change, dual
// enables, enable freeze and asynchronous reset mid-transaction.
module tb_load_store_unit;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] rs;
    logic [7:0] rt;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        core_state = 3'b000;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; core_state = 3'b000;
        rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
        mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_state", lsu_state, 2'd0);
        chk("rst_rvalid", mem_read_valid, 1'b0);
        chk("rst_wvalid", mem_write_valid, 1'b0);
        chk("rst_raddr", mem_read_address, 8'h00);
        chk("rst_waddr", mem_write_address, 8'h00);
        chk("rst_wdata", mem_write_data, 8'h00);
        chk("rst_out", lsu_out, 8'h00);

        @(negedge clk);
        reset = 1'b1; enable = 1'b1;

        // Load with a 3-cycle ready delay
        core_state = 3'b011; rd_en = 1'b1; rs = 8'h20;
        tick();
        chk("ld_req_state", lsu_state, 2'd1);
        chk("ld_req_rvalid", mem_read_valid, 1'b0);
        clear_req(); rs = 8'hFF;
        tick();
        chk("ld_wait_state", lsu_state, 2'd2);
        chk("ld_rvalid", mem_read_valid, 1'b1);
        chk("ld_raddr", mem_read_address, 8'h20);
        chk("ld_wvalid", mem_write_valid, 1'b0);
        tick();
        chk("ld_hold1_rvalid", mem_read_valid, 1'b1);
        chk("ld_hold1_raddr", mem_read_address, 8'h20);
        tick();
        chk("ld_hold2_rvalid", mem_read_valid, 1'b1);
        chk("ld_hold2_state", lsu_state, 2'd2);
        mem_read_ready = 1'b1; mem_read_data = 8'hA5;
        tick();
        chk("ld_done_state", lsu_state, 2'd3);
        chk("ld_done_rvalid", mem_read_valid, 1'b0);
        chk("ld_done_out", lsu_out, 8'hA5);
        mem_read_data = 8'h5A;
        tick();
        chk("ld_done_ready_ignored", lsu_out, 8'hA5);
        chk("ld_done_hold", lsu_state, 2'd3);
        mem_read_ready = 1'b0; core_state = 3'b110;
        tick();
        chk("ld_idle", lsu_state, 2'd0);
        core_state = 3'b000;

        // Store completing on the first valid cycle
        core_state = 3'b011; wr_en = 1'b1; rs = 8'h07; rt = 8'h3C;
        tick();
        chk("st_req_state", lsu_state, 2'd1);
        clear_req(); rs = 8'h00; rt = 8'h00;
        tick();
        chk("st_wvalid", mem_write_valid, 1'b1);
        chk("st_waddr", mem_write_address, 8'h07);
        chk("st_wdata", mem_write_data, 8'h3C);
        chk("st_rvalid", mem_read_valid, 1'b0);
        mem_write_ready = 1'b1;
        tick();
        chk("st_wvalid_pulse", mem_write_valid, 1'b0);
        chk("st_done_state", lsu_state, 2'd3);
        chk("st_out_unchanged", lsu_out, 8'hA5);
        mem_write_ready = 1'b0; core_state = 3'b110;
        tick();
        chk("st_idle", lsu_state, 2'd0);
        core_state = 3'b000;

        // Operand change after REQUEST, plus wrong-channel ready
        core_state = 3'b011; rd_en = 1'b1; rs = 8'h10;
        tick();
        clear_req(); rs = 8'hFF;
        tick();
        chk("opc_raddr", mem_read_address, 8'h10);
        mem_write_ready = 1'b1;
        tick();
        chk("opc_wrong_ready_state", lsu_state, 2'd2);
        chk("opc_wrong_ready_rvalid", mem_read_valid, 1'b1);
        chk("opc_raddr_hold", mem_read_address, 8'h10);
        mem_write_ready = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'hC3;
        tick();
        chk("opc_done_out", lsu_out, 8'hC3);
        mem_read_ready = 1'b0; core_state = 3'b110;
        tick();
        chk("opc_idle", lsu_state, 2'd0);
        core_state = 3'b000;

        // Both enables: read wins
        core_state = 3'b011; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h01; rt = 8'h99;
        tick();
        clear_req();
        tick();
        chk("both_rvalid", mem_read_valid, 1'b1);
        chk("both_wvalid", mem_write_valid, 1'b0);
        chk("both_raddr", mem_read_address, 8'h01);

        // Enable freeze in WAITING with a ready pulse while disabled
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_read_ready = (i == 1); mem_read_data = 8'hEE;
            tick();
            chk("frz_state", lsu_state, 2'd2);
            chk("frz_rvalid", mem_read_valid, 1'b1);
            chk("frz_out", lsu_out, 8'hC3);
        end
        mem_read_ready = 1'b0; enable = 1'b1;
        tick();
        chk("frz_resume_state", lsu_state, 2'd2);
        chk("frz_resume_raddr", mem_read_address, 8'h01);
        mem_read_ready = 1'b1; mem_read_data = 8'h4B;
        tick();
        chk("frz_done_state", lsu_state, 2'd3);
        chk("frz_done_out", lsu_out, 8'h4B);
        mem_read_ready = 1'b0;
        enable = 1'b0; core_state = 3'b110;
        tick();
        chk("frz_done_hold", lsu_state, 2'd3);
        enable = 1'b1;
        tick();
        chk("frz_idle", lsu_state, 2'd0);
        core_state = 3'b000;

        // Asynchronous reset mid-WAITING
        core_state = 3'b011; rd_en = 1'b1; rs = 8'h55;
        tick();
        clear_req();
        tick();
        chk("ar_pre_rvalid", mem_read_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("ar_state", lsu_state, 2'd0);
        chk("ar_rvalid", mem_read_valid, 1'b0);
        chk("ar_raddr", mem_read_address, 8'h00);
        chk("ar_waddr", mem_write_address, 8'h00);
        chk("ar_wdata", mem_write_data, 8'h00);
        chk("ar_out", lsu_out, 8'h00);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_post_state", lsu_state, 2'd0);
            chk("ar_post_rvalid", mem_read_valid, 1'b0);
        end
        core_state = 3'b011; rd_en = 1'b1; rs = 8'h66;
        tick();
        chk("ar_new_req", lsu_state, 2'd1);
        clear_req();
        tick();
        chk("ar_new_rvalid", mem_read_valid, 1'b1);
        chk("ar_new_raddr", mem_read_address, 8'h66);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_BITS, default 8, memory address width.
REQ-002 Parameter: DATA_BITS, default 8, memory data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  thread active in current block; when low, the FSM and all outputs hold their value.
REQ-006 core_state  input  3  core phase; 3'b011 = REQUEST, 3'b110 = UPDATE.
REQ-007 decoded_mem_read_enable  input  1  current instruction is LDR.
REQ-008 decoded_mem_write_enable  input  1  current instruction is STR.
REQ-009 rs  input  DATA_BITS  register-file read_data1; the memory address.
REQ-010 rt  input  DATA_BITS  register-file read_data2; the store data.
REQ-011 mem_read_valid  output  1  read request valid.
REQ-012 mem_read_address  output  ADDR_BITS  read address.
REQ-013 mem_read_ready  input  1  memory has returned read data this cycle.
REQ-014 mem_read_data  input  DATA_BITS  returned read data.
REQ-015 mem_write_valid  output  1  write request valid.
REQ-016 mem_write_address  output  ADDR_BITS  write address.
REQ-017 mem_write_data  output  DATA_BITS  write data.
REQ-018 mem_write_ready  input  1  memory has accepted the write this cycle.
REQ-019 lsu_state  output  2  IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
REQ-020 lsu_out  output  DATA_BITS  load result, consumed as register-file write_data.

Function
REQ-021 FSM encoding SHALL be fixed as in REQ-019; lsu_state SHALL be the registered FSM state.
REQ-022 IDLE -> REQUESTING SHALL occur on a clock edge where enable=1, core_state=3'b011 and either decoded enable is 1; otherwise IDLE SHALL hold.
REQ-023 On the IDLE->REQUESTING edge, the unit SHALL latch rs as the address, latch rt as the data, and latch op = read if decoded_mem_read_enable=1, else write (read wins if both are 1).
REQ-024 REQUESTING -> WAITING SHALL occur unconditionally after one cycle; on that edge, the unit SHALL set mem_read_valid=1 (read op) or mem_write_valid=1 (write op), and drive the latched address/data onto the corresponding address/data outputs.
REQ-025 In WAITING, valid SHALL stay high and address/data SHALL stay stable until the matching ready is sampled high.
REQ-026 On the WAITING edge where the matching ready=1, valid SHALL go 0; a read SHALL capture mem_read_data into lsu_out; state SHALL go to DONE.
REQ-027 In WAITING, a ready for the non-active channel SHALL be ignored.
REQ-028 A ready sampled high outside WAITING SHALL be ignored.
REQ-029 DONE -> IDLE SHALL occur on the edge where core_state=3'b110; otherwise DONE SHALL hold.
REQ-030 lsu_out SHALL change only on a read completion.
REQ-031 A write SHALL NOT alter lsu_out.
REQ-032 Minimum request-to-completion latency: valid rises 2 edges after the REQUEST edge, and DONE is entered on the first edge with ready=1 (ready may be high on the same edge valid is first seen).
REQ-033 enable=0 in any state SHALL freeze state, valids, addresses, data and lsu_out; operation SHALL resume unchanged when enable returns to 1.
REQ-034 Address output SHALL be the low ADDR_BITS of the latched rs; upper bits SHALL be discarded.

Reset
REQ-035 reset=0 SHALL immediately, without a clock, force lsu_state=IDLE and clear to 0: mem_read_valid, mem_write_valid, all addresses, mem_write_data, lsu_out and the latched op.
REQ-036 Reset asserted mid-transaction SHALL abort it with no further valid assertion after release.
REQ-037 The first active edge after reset release SHALL behave as IDLE.

Verification
REQ-038 Load: rs=8'h20, read_en=1, core_state=011, memory returns 8'hA5 with 3-cycle ready delay -> mem_read_valid high with address 8'h20 until ready; then lsu_out=8'hA5, lsu_state=3; after core_state=110, lsu_state=0.
REQ-039 Store: rs=8'h07, rt=8'h3C, write_en=1, ready on the first valid cycle -> mem_write_valid pulses for exactly 1 cycle with address 8'h07 and data 8'h3C; lsu_out is unchanged.
REQ-040 Operand change: rs changes from 8'h10 to 8'hFF one cycle after REQUEST -> mem_read_address stays 8'h10.
REQ-041 Both enables set with rs=8'h01 -> only mem_read_valid asserts; mem_write_valid stays 0.
REQ-042 enable dropped for 4 cycles during WAITING, with ready pulsed while disabled -> state, valid and lsu_out frozen; completion occurs only on a ready seen after re-enable.
REQ-043 reset pulsed low mid-clock while in WAITING -> all outputs are 0 and lsu_state=0 before the next edge; no valid reasserts until a new REQUEST.
